// File: rtl/audio_downmix_preemph.sv
// Stereo-to-mono downmix with first-order pre-emphasis and frame markers.
// Consumes interleaved ch1/ch2 words and emits one saturated signed sample per pair.
module audio_downmix_preemph #(
   parameter int unsigned FRAME_LEN     = 256,
   parameter int unsigned PREEMPH_SHIFT = 5
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        init_i,
   input  logic [15:0] audio_i,
   input  logic        audio_valid_i,
   output logic        audio_rdy_o,
   output logic [15:0] sample_o,
   output logic        sample_valid_o,
   input  logic        sample_rdy_i,
   output logic        frame_start_o,
   output logic        frame_last_o
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned SUM_W  = DATA_W + 1;
   localparam int unsigned EXT_W  = DATA_W + 2;
   localparam int unsigned CNT_W  = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      S_CH1 = 2'd0,
      S_CH2 = 2'd1,
      S_OUT = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic signed [DATA_W-1:0]  ch1_q, ch1_d;
   logic signed [DATA_W-1:0]  m_q, m_d;
   logic signed [DATA_W-1:0]  prev_q, prev_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic signed [DATA_W-1:0]  sample_q, sample_d;
   logic                      valid_q, valid_d;
   logic                      start_q, start_d;
   logic                      last_q, last_d;

   logic signed [SUM_W-1:0]   sum_s;
   logic signed [DATA_W-1:0]  mono_s;
   logic signed [EXT_W-1:0]   prev_s;
   logic signed [EXT_W-1:0]   pterm_s;
   logic signed [EXT_W-1:0]   y_s;
   logic signed [DATA_W-1:0]  y_sat;
   logic                      in_xfer;
   logic                      out_xfer;

   // Upstream is only accepted while collecting a pair, never during reset or init.
   assign audio_rdy_o = rst_ni & ~init_i & (state_q != S_OUT);

   assign in_xfer  = audio_valid_i & audio_rdy_o;
   assign out_xfer = valid_q & sample_rdy_i;

   // Mono mix (floor of the average) and pre-emphasis against the previous mono value.
   always_comb begin
      sum_s   = SUM_W'(ch1_q) + SUM_W'($signed(audio_i));
      mono_s  = sum_s[SUM_W-1:1];
      prev_s  = EXT_W'(prev_q);
      pterm_s = prev_s - (prev_s >>> PREEMPH_SHIFT);
      y_s     = EXT_W'(mono_s) - pterm_s;
      if (y_s > 18'sd32767) begin
         y_sat = 16'sh7FFF;
      end else if (y_s < -18'sd32768) begin
         y_sat = 16'sh8000;
      end else begin
         y_sat = y_s[DATA_W-1:0];
      end
   end

   always_comb begin
      state_d  = state_q;
      ch1_d    = ch1_q;
      m_d      = m_q;
      prev_d   = prev_q;
      cnt_d    = cnt_q;
      sample_d = sample_q;
      valid_d  = valid_q;
      start_d  = start_q;
      last_d   = last_q;

      if (init_i) begin
         state_d = S_CH1;
         ch1_d   = '0;
         m_d     = '0;
         prev_d  = '0;
         cnt_d   = '0;
         valid_d = 1'b0;
         start_d = 1'b0;
         last_d  = 1'b0;
      end else begin
         case (state_q)
            S_CH1: begin
               if (in_xfer) begin
                  ch1_d   = $signed(audio_i);
                  state_d = S_CH2;
               end
            end
            S_CH2: begin
               if (in_xfer) begin
                  m_d      = mono_s;
                  sample_d = y_sat;
                  valid_d  = 1'b1;
                  start_d  = (cnt_q == '0);
                  last_d   = (cnt_q == CNT_LAST);
                  state_d  = S_OUT;
               end
            end
            S_OUT: begin
               if (out_xfer) begin
                  prev_d  = m_q;
                  cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
                  valid_d = 1'b0;
                  start_d = 1'b0;
                  last_d  = 1'b0;
                  state_d = S_CH1;
               end
            end
            default: state_d = S_CH1;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_CH1;
         ch1_q    <= '0;
         m_q      <= '0;
         prev_q   <= '0;
         cnt_q    <= '0;
         sample_q <= '0;
         valid_q  <= 1'b0;
         start_q  <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ch1_q    <= ch1_d;
         m_q      <= m_d;
         prev_q   <= prev_d;
         cnt_q    <= cnt_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
         start_q  <= start_d;
         last_q   <= last_d;
      end
   end

   assign sample_o       = sample_q;
   assign sample_valid_o = valid_q;
   assign frame_start_o  = start_q;
   assign frame_last_o   = last_q;

endmodule
